// File: rtl/pipe_pkg.sv
// Shared constants and encodings for the inter-stage pipeline register.
package pipe_pkg;

  // Default bubble payload: all-zero word (MIPS sll r0,r0,0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// stall/flush control and saturating stall/flush counters.
//
//   state     | meaning
//   OCC_EMPTY | no payload held, bubble presented downstream
//   OCC_ONE   | main entry valid, skid entry free
//   OCC_TWO   | main and skid entries valid (SKID=1 only), upstream blocked
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE   = DATA_W'(NOP_INSN),
  parameter bit                SKID        = 1'b1,
  parameter int                CNT_W       = CNT_W_DEFAULT,
  parameter bit                CLK_NEGEDGE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Every flop in this block, counters included, runs off the selected edge.
  logic clk_act;
  assign clk_act = CLK_NEGEDGE ? ~clk : clk;

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_rdy_q, in_rdy_d;
  logic              main_valid, accept, drain;

  assign main_valid = (occ_q != OCC_EMPTY);
  assign in_ready   = ~stall & (SKID ? in_rdy_q : (~main_valid | out_ready));
  assign out_valid  = main_valid & ~stall;
  assign out_data   = out_valid ? main_q : NOP_VALUE;
  assign occupancy  = occ_q;
  assign accept     = in_valid & in_ready;
  assign drain      = out_valid & out_ready;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d  = OCC_EMPTY;
      main_d = NOP_VALUE;
      skid_d = NOP_VALUE;
    end else if (!stall) begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_d = in_data;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Without a skid entry an accept here always coincides with a drain.
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d = in_data;
            occ_d  = OCC_TWO;
          end else if (drain) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (drain) begin
            main_d = skid_q;
            if (accept) begin
              skid_d = in_data;
            end else begin
              occ_d = OCC_ONE;
            end
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
    in_rdy_d = (occ_d != OCC_TWO);
  end

  always_ff @(posedge clk_act) begin
    if (rst) begin
      occ_q    <= OCC_EMPTY;
      main_q   <= NOP_VALUE;
      skid_q   <= NOP_VALUE;
      in_rdy_q <= 1'b1;
    end else begin
      occ_q    <= occ_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk_act),
    .clr (rst),
    .inc (stall & ~flush),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk_act),
    .clr (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );

endmodule
